// File: rtl/drisc_monitor_pkg.sv
// ---------------------------------------------------------------------------
// drisc_monitor_pkg
// Shared types and constants for the drisc run monitor.
//   halt_cause_t     : 3-bit halt cause code reported on halt_cause
//   monitor_state_t  : WARMUP / RUN / HALTED monitor state
//   OPC_*            : the 7-bit major opcodes the core accepts
//   is_legal_opcode  : 1 when an opcode is one of the OPC_* values
// ---------------------------------------------------------------------------
package drisc_monitor_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_LOOP    = 3'd1,
        CAUSE_ILLEGAL = 3'd2,
        CAUSE_LIMIT   = 3'd3,
        CAUSE_TIMEOUT = 3'd4
    } halt_cause_t;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } monitor_state_t;

    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_LOAD_FP = 7'h07;
    localparam logic [6:0] OPC_OP_IMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_AMO     = 7'h2F;
    localparam logic [6:0] OPC_OP      = 7'h33;
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_OP_FP   = 7'h53;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_JAL     = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73;

    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        logic legal;
        case (opcode)
            OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
            OPC_AMO, OPC_OP, OPC_LUI, OPC_OP_FP, OPC_BRANCH,
            OPC_JALR, OPC_JAL, OPC_SYSTEM: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/drisc_run_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, counter -> 0
//   inc    : count up by one this cycle (ignored once saturated)
//   clr    : synchronous clear, wins over inc
//   count  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !(&count_reg)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/drisc_run_monitor.sv
// ---------------------------------------------------------------------------
// drisc_run_monitor
// Watches the drisc retire stream and raises a sticky halt request when the
// program self-loops, retires an illegal opcode, exhausts its instruction
// budget or stops retiring for too long.
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   retire      : one-cycle strobe per retired instruction
//   pc_current  : PC of the retiring instruction (valid with retire)
//   pc_next     : PC following the retiring instruction (valid with retire)
//   opcode      : opcode of the retiring instruction (valid with retire)
//   clear       : synchronous restart of counters, state and cause
//   halt        : sticky halt request
//   halt_cause  : 0 none, 1 loop, 2 illegal, 3 limit, 4 timeout
//   halt_pc     : pc_current of the halting retire, 0 for a timeout
//   instr_count : saturating retire count since reset/clear
//   cycle_count : saturating cycle count since reset/clear
// ---------------------------------------------------------------------------
module drisc_run_monitor
    import drisc_monitor_pkg::*;
#(
    parameter int PC_WIDTH            = 32,
    parameter int COUNT_WIDTH         = 32,
    parameter int MAX_INSTRUCTIONS    = 10000,
    parameter int WARMUP_INSTRUCTIONS = 4,
    parameter int LOOP_REPEAT         = 1,
    parameter int TIMEOUT_CYCLES      = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   retire,
    input  logic [PC_WIDTH-1:0]    pc_current,
    input  logic [PC_WIDTH-1:0]    pc_next,
    input  logic [6:0]             opcode,
    input  logic                   clear,
    output logic                   halt,
    output logic [2:0]             halt_cause,
    output logic [PC_WIDTH-1:0]    halt_pc,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    localparam int CNT_INSTR  = 0;
    localparam int CNT_CYCLE  = 1;
    localparam int CNT_IDLE   = 2;
    localparam int CNT_REPEAT = 3;
    localparam int NUM_CNT    = 4;

    localparam logic [COUNT_WIDTH-1:0] MAX_C    = COUNT_WIDTH'(MAX_INSTRUCTIONS);
    localparam logic [COUNT_WIDTH-1:0] WARMUP_C = COUNT_WIDTH'(WARMUP_INSTRUCTIONS);
    localparam logic [COUNT_WIDTH-1:0] REPEAT_C = COUNT_WIDTH'(LOOP_REPEAT);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT_CYCLES);

    monitor_state_t      state_reg, state_next;
    halt_cause_t         cause_reg, cause_next;
    logic                halt_reg, halt_next;
    logic [PC_WIDTH-1:0] halt_pc_reg, halt_pc_next;

    logic [NUM_CNT-1:0]     cnt_inc;
    logic [NUM_CNT-1:0]     cnt_clr;
    logic [COUNT_WIDTH-1:0] cnt_value [NUM_CNT];

    // ------------------------------------------------------------------
    // Counter bank: instructions, cycles, idle cycles, loop repeats
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(
                .WIDTH (COUNT_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .clr   (cnt_clr[gi]),
                .count (cnt_value[gi])
            );
        end
    endgenerate

    logic                   active;
    logic                   retire_acc;
    logic                   checks_armed;
    logic                   pc_match;
    logic [COUNT_WIDTH-1:0] instr_plus1;
    logic [COUNT_WIDTH-1:0] idle_plus1;
    logic [COUNT_WIDTH-1:0] repeat_plus1;
    logic                   warm_reached;
    logic                   loop_hit;
    logic                   illegal_hit;
    logic                   limit_hit;
    logic                   timeout_hit;
    halt_cause_t            win_cause;

    assign active     = (state_reg != ST_HALTED);
    // A retire coinciding with clear is dropped; retires are ignored once halted.
    assign retire_acc = retire && !clear && active;
    // With no warmup budget the first cycle after reset/clear is already armed.
    assign checks_armed = (state_reg == ST_RUN) ||
                          ((state_reg == ST_WARMUP) && (WARMUP_INSTRUCTIONS == 0));
    assign pc_match     = (pc_current == pc_next);
    assign instr_plus1  = cnt_value[CNT_INSTR] + 1'b1;
    assign idle_plus1   = cnt_value[CNT_IDLE] + 1'b1;
    assign repeat_plus1 = cnt_value[CNT_REPEAT] + 1'b1;

    always_comb begin
        cnt_inc = '0;
        cnt_clr = '0;

        cnt_clr[CNT_INSTR]  = clear;
        cnt_inc[CNT_INSTR]  = retire_acc;

        cnt_clr[CNT_CYCLE]  = clear;
        cnt_inc[CNT_CYCLE]  = active;

        cnt_clr[CNT_IDLE]   = clear || retire;
        cnt_inc[CNT_IDLE]   = active;

        // Repeat count is held at zero while the loop check is masked.
        cnt_clr[CNT_REPEAT] = clear || !checks_armed || (retire && !pc_match);
        cnt_inc[CNT_REPEAT] = retire_acc && checks_armed && pc_match;
    end

    // Detection compares the value each counter is about to take, so the halt
    // lands on the same edge that samples the triggering retire.
    assign warm_reached = (WARMUP_INSTRUCTIONS == 0) ||
                          (retire_acc && (instr_plus1 == WARMUP_C));

    assign loop_hit    = retire_acc && checks_armed && pc_match &&
                         !(&cnt_value[CNT_REPEAT]) && (repeat_plus1 == REPEAT_C);
    assign illegal_hit = retire_acc && checks_armed && !is_legal_opcode(opcode);
    assign limit_hit   = (MAX_INSTRUCTIONS != 0) && retire_acc &&
                         !(&cnt_value[CNT_INSTR]) && (instr_plus1 == MAX_C);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && active && !clear && !retire &&
                         !(&cnt_value[CNT_IDLE]) && (idle_plus1 == TIMEOUT_C);

    always_comb begin
        win_cause = CAUSE_NONE;
        if (loop_hit) begin
            win_cause = CAUSE_LOOP;
        end else if (illegal_hit) begin
            win_cause = CAUSE_ILLEGAL;
        end else if (limit_hit) begin
            win_cause = CAUSE_LIMIT;
        end else if (timeout_hit) begin
            win_cause = CAUSE_TIMEOUT;
        end
    end

    // ------------------------------------------------------------------
    // Monitor FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_WARMUP;
            cause_reg   <= CAUSE_NONE;
            halt_reg    <= 1'b0;
            halt_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cause_reg   <= cause_next;
            halt_reg    <= halt_next;
            halt_pc_reg <= halt_pc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cause_next   = cause_reg;
        halt_next    = halt_reg;
        halt_pc_next = halt_pc_reg;

        if (clear) begin
            state_next   = ST_WARMUP;
            cause_next   = CAUSE_NONE;
            halt_next    = 1'b0;
            halt_pc_next = '0;
        end else begin
            case (state_reg)
                ST_WARMUP, ST_RUN: begin
                    if ((state_reg == ST_WARMUP) && warm_reached) begin
                        state_next = ST_RUN;
                    end
                    if (win_cause != CAUSE_NONE) begin
                        state_next   = ST_HALTED;
                        cause_next   = win_cause;
                        halt_next    = 1'b1;
                        halt_pc_next = (win_cause == CAUSE_TIMEOUT) ? '0 : pc_current;
                    end
                end
                default: begin
                    // HALTED: only clear or reset leaves this state
                end
            endcase
        end
    end

    assign halt        = halt_reg;
    assign halt_cause  = cause_reg;
    assign halt_pc     = halt_pc_reg;
    assign instr_count = cnt_value[CNT_INSTR];
    assign cycle_count = cnt_value[CNT_CYCLE];

endmodule

// File: tb/tb_drisc_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_drisc_run_monitor
// Two monitors with different parameter sets share one input stream; both
// are compared every cycle against a behavioural model of the run rules.
//   dut_a : MAX=40, WARMUP=4, LOOP_REPEAT=3, TIMEOUT=64
//   dut_b : MAX=10, WARMUP=0, LOOP_REPEAT=1, TIMEOUT=16
// ---------------------------------------------------------------------------
module tb_drisc_run_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retire = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] pc_current = '0;
    logic [31:0] pc_next = '0;
    logic [6:0]  opcode = 7'h13;

    logic        a_halt, b_halt;
    logic [2:0]  a_cause, b_cause;
    logic [31:0] a_hpc, b_hpc, a_ic, b_ic, a_cc, b_cc;

    always #5 clk = ~clk;

    drisc_run_monitor #(
        .PC_WIDTH(32), .COUNT_WIDTH(32), .MAX_INSTRUCTIONS(40),
        .WARMUP_INSTRUCTIONS(4), .LOOP_REPEAT(3), .TIMEOUT_CYCLES(64)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .retire(retire), .pc_current(pc_current),
        .pc_next(pc_next), .opcode(opcode), .clear(clear), .halt(a_halt),
        .halt_cause(a_cause), .halt_pc(a_hpc), .instr_count(a_ic),
        .cycle_count(a_cc)
    );

    drisc_run_monitor #(
        .PC_WIDTH(32), .COUNT_WIDTH(32), .MAX_INSTRUCTIONS(10),
        .WARMUP_INSTRUCTIONS(0), .LOOP_REPEAT(1), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .retire(retire), .pc_current(pc_current),
        .pc_next(pc_next), .opcode(opcode), .clear(clear), .halt(b_halt),
        .halt_cause(b_cause), .halt_pc(b_hpc), .instr_count(b_ic),
        .cycle_count(b_cc)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state, one slot per DUT
    int          p_max  [2] = '{40, 10};
    int          p_warm [2] = '{4, 0};
    int          p_rep  [2] = '{3, 1};
    int          p_to   [2] = '{64, 16};
    bit          m_halt [2];
    int unsigned m_cause[2];
    int unsigned m_hpc  [2];
    int unsigned m_ic   [2];
    int unsigned m_cc   [2];
    int unsigned m_idle [2];
    int unsigned m_rep  [2];

    logic [7:0] legal_list [13] = '{8'h03, 8'h07, 8'h13, 8'h17, 8'h23, 8'h2F, 8'h33,
                                    8'h37, 8'h53, 8'h63, 8'h67, 8'h6F, 8'h73};

    function automatic bit ref_legal(input logic [6:0] op);
        foreach (legal_list[i]) begin
            if ({1'b0, op} == legal_list[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0; m_cause[k] = 0; m_hpc[k] = 0; m_ic[k] = 0;
            m_cc[k] = 0; m_idle[k] = 0; m_rep[k] = 0;
        end
    endtask

    // Predicts the outputs after the coming clock edge from the current inputs.
    task automatic model_step(input int k);
        bit          masked;
        int unsigned win;
        if (clear) begin
            m_halt[k] = 0; m_cause[k] = 0; m_hpc[k] = 0; m_ic[k] = 0;
            m_cc[k] = 0; m_idle[k] = 0; m_rep[k] = 0;
            return;
        end
        if (m_halt[k]) return;
        masked = (m_ic[k] < p_warm[k]);
        win = 0;
        m_cc[k]++;
        if (retire) begin
            m_ic[k]++;
            m_idle[k] = 0;
            if (!masked && pc_current == pc_next) m_rep[k]++;
            else m_rep[k] = 0;
            if (!masked && pc_current == pc_next && m_rep[k] == p_rep[k]) win = 1;
            else if (!masked && !ref_legal(opcode)) win = 2;
            else if (p_max[k] != 0 && m_ic[k] == p_max[k]) win = 3;
        end else begin
            m_idle[k]++;
            if (p_to[k] != 0 && m_idle[k] == p_to[k]) win = 4;
        end
        if (win != 0) begin
            m_halt[k] = 1;
            m_cause[k] = win;
            m_hpc[k] = (win == 4) ? 0 : pc_current;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " a.halt"},  {31'b0, a_halt}, {31'b0, m_halt[0]});
        check({ph, " a.cause"}, {29'b0, a_cause}, m_cause[0]);
        check({ph, " a.hpc"},   a_hpc, m_hpc[0]);
        check({ph, " a.instr"}, a_ic, m_ic[0]);
        check({ph, " a.cycle"}, a_cc, m_cc[0]);
        check({ph, " b.halt"},  {31'b0, b_halt}, {31'b0, m_halt[1]});
        check({ph, " b.cause"}, {29'b0, b_cause}, m_cause[1]);
        check({ph, " b.hpc"},   b_hpc, m_hpc[1]);
        check({ph, " b.instr"}, b_ic, m_ic[1]);
        check({ph, " b.cycle"}, b_cc, m_cc[1]);
    endtask

    task automatic step(input string ph, input logic r, input logic [31:0] pc,
                        input logic [31:0] pn, input logic [6:0] op, input logic clr);
        retire = r; pc_current = pc; pc_next = pn; opcode = op; clear = clr;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    initial begin
        logic        r_r, r_c;
        logic [31:0] r_pc, r_pn;
        logic [6:0]  r_op;
        int          pct;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Straight-line program: dut_b hits its limit of 10
        for (int i = 0; i < 10; i++) begin
            step("straight", 1'b1, 32'h100 + 4*i, 32'h104 + 4*i, 7'h13, 1'b0);
            if (i == 8) check("straight b.no_halt_at_9", {31'b0, b_halt}, 32'd0);
        end
        check("straight b.cause", {29'b0, b_cause}, 32'd3);
        check("straight b.instr", b_ic, 32'd10);
        check("straight a.halt", {31'b0, a_halt}, 32'd0);

        // Self-loop after warmup
        step("clear1", 1'b0, 32'h0, 32'h0, 7'h13, 1'b1);
        for (int i = 0; i < 4; i++)
            step("loop_warm", 1'b1, 32'h10 + 4*i, 32'h14 + 4*i, 7'h33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("loop", 1'b1, 32'h40, 32'h40, 7'h63, 1'b0);
            if (i == 1) check("loop a.no_halt_at_2", {31'b0, a_halt}, 32'd0);
        end
        check("loop a.cause", {29'b0, a_cause}, 32'd1);
        check("loop a.hpc", a_hpc, 32'h40);

        // Illegal opcode inside and after warmup
        step("clear2", 1'b0, 32'h0, 32'h0, 7'h13, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step("illegal", 1'b1, 32'h200 + 4*i, 32'h204 + 4*i,
                 (i == 1 || i == 5) ? 7'h7F : 7'h13, 1'b0);
            if (i == 1) check("illegal a.masked", {31'b0, a_halt}, 32'd0);
        end
        check("illegal a.cause", {29'b0, a_cause}, 32'd2);
        check("illegal a.hpc", a_hpc, 32'h214);

        // Retire stall: timeout 64 cycles after the 5th retire
        step("clear3", 1'b0, 32'h0, 32'h0, 7'h13, 1'b1);
        for (int i = 0; i < 5; i++)
            step("to_ret", 1'b1, 32'h300 + 4*i, 32'h304 + 4*i, 7'h03, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step("to_idle", 1'b0, 32'h0, 32'h0, 7'h13, 1'b0);
            if (i == 62) check("timeout a.no_halt_at_63", {31'b0, a_halt}, 32'd0);
        end
        check("timeout a.cause", {29'b0, a_cause}, 32'd4);
        check("timeout a.hpc", a_hpc, 32'd0);
        check("timeout a.instr", a_ic, 32'd5);

        // LOOP beats ILLEGAL on the same retire, then clear
        step("clear4", 1'b0, 32'h0, 32'h0, 7'h13, 1'b1);
        for (int i = 0; i < 4; i++)
            step("prio_warm", 1'b1, 32'h400 + 4*i, 32'h404 + 4*i, 7'h13, 1'b0);
        step("prio", 1'b1, 32'h80, 32'h80, 7'h7F, 1'b0);
        check("prio b.cause", {29'b0, b_cause}, 32'd1);
        check("prio a.cause", {29'b0, a_cause}, 32'd2);
        step("prio_clear", 1'b1, 32'h90, 32'h94, 7'h13, 1'b1);
        check("clear b.halt", {31'b0, b_halt}, 32'd0);
        check("clear b.instr", b_ic, 32'd0);
        check("clear b.cycle", b_cc, 32'd0);
        step("clear_warm", 1'b1, 32'h500, 32'h504, 7'h7F, 1'b0);
        check("clear a.warm_masked", {31'b0, a_halt}, 32'd0);

        // Asynchronous reset mid-run
        step("clear5", 1'b0, 32'h0, 32'h0, 7'h13, 1'b1);
        for (int i = 0; i < 7; i++)
            step("pre_rst", 1'b1, 32'h600 + 4*i, 32'h604 + 4*i, 7'h13, 1'b0);
        check("pre_rst a.instr", a_ic, 32'd7);
        retire = 1'b0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("held_rst");
        rst_n = 1'b1;
        step("post_rst", 1'b1, 32'h700, 32'h704, 7'h13, 1'b0);
        step("post_rst", 1'b1, 32'h704, 32'h708, 7'h7F, 1'b0);
        check("post_rst a.warm_masked", {31'b0, a_halt}, 32'd0);

        // Randomized traffic with occasional clears and stall phases
        for (int i = 0; i < 600; i++) begin
            pct  = (i >= 250 && i < 350) ? 3 : 65;
            r_r  = ($urandom_range(0, 99) < pct);
            r_pc = 32'($urandom_range(0, 15)) * 4;
            r_pn = ($urandom_range(0, 3) == 0) ? r_pc : r_pc + 4;
            if ($urandom_range(0, 19) == 0) r_op = 7'($urandom_range(0, 127));
            else r_op = legal_list[$urandom_range(0, 12)][6:0];
            r_c  = ($urandom_range(0, 29) == 0);
            step("random", r_r, r_pc, r_pn, r_op, r_c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drisc_run_monitor.md
# drisc_run_monitor

Synthesizable run monitor for the drisc core. It observes instruction-boundary strobes, the PC pair and the opcode, and counts retired instructions and clock cycles. It detects self-loops, illegal opcodes, instruction-limit exhaustion and retire-stall timeouts, then latches a halt request with a cause code. It sits beside the core in both simulation and FPGA builds, and replaces behavioural end-of-run checks with hardware that is parametrised for PC width, limits and loop tolerance.

## Interface
- PC_WIDTH, 32, width of PC inputs
- COUNT_WIDTH, 32, width of instruction and cycle counters
- MAX_INSTRUCTIONS, 10000, retire count that triggers LIMIT; 0 disables the check
- WARMUP_INSTRUCTIONS, 4, retires ignored by the LOOP and ILLEGAL checks after reset or clear
- LOOP_REPEAT, 1, consecutive retires with pc_current == pc_next required for LOOP (≥1)
- TIMEOUT_CYCLES, 64, cycles without a retire that trigger TIMEOUT; 0 disables the check

- clock  in  1  system clock; all state is updated on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- retire  in  1  single-cycle strobe at each instruction boundary
- pc_current  in  PC_WIDTH  PC of the retiring instruction; sampled when retire=1
- pc_next  in  PC_WIDTH  next PC; sampled when retire=1
- opcode  in  7  opcode of the retiring instruction; sampled when retire=1
- clear  in  1  synchronous restart: counters→0, state→WARMUP, cause→NONE
- halt  out  1  sticky halt request
- halt_cause  out  3  0 NONE, 1 LOOP, 2 ILLEGAL, 3 LIMIT, 4 TIMEOUT
- halt_pc  out  PC_WIDTH  pc_current at the halting retire; 0 for TIMEOUT
- instr_count  out  COUNT_WIDTH  retires since reset or clear, saturating
- cycle_count  out  COUNT_WIDTH  cycles since reset or clear, saturating

## Operation
- States: WARMUP, RUN, HALTED.
  - Reset state is WARMUP.
  - WARMUP→RUN when instr_count reaches WARMUP_INSTRUCTIONS. If WARMUP_INSTRUCTIONS=0, the block goes straight to RUN.
  - RUN→HALTED on any detected cause.
  - HALTED exits only through clear or reset.
- Legal opcodes: 03, 07, 13, 17, 23, 2F, 33, 37, 53, 63, 67, 6F, 73 (hex). Any other opcode is ILLEGAL.
- LOOP detection:
  - A repeat counter increments on each retire with pc_current == pc_next and resets to 0 on any other retire.
  - LOOP fires when the counter reaches LOOP_REPEAT.
- LIMIT fires on the retire that makes instr_count == MAX_INSTRUCTIONS. This check is active in WARMUP as well as RUN.
- TIMEOUT:
  - An idle counter clears on retire and otherwise increments.
  - TIMEOUT fires when the counter reaches TIMEOUT_CYCLES. This check is active in both WARMUP and RUN.
- Counters:
  - Both instr_count and cycle_count stop at all-ones (saturate, no wrap).
  - In HALTED, both counters freeze.
- Priority when several causes fire in the same cycle: LOOP > ILLEGAL > LIMIT > TIMEOUT. Only the winning cause is latched.
- During WARMUP, the LOOP and ILLEGAL checks are fully masked. The repeat counter is also held at 0.
- clear and retire in the same cycle: clear wins and the retire is discarded.
- Reset mid-run: all outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- Reset values:
  - halt=0
  - halt_cause=0
  - halt_pc=0
  - instr_count=0
  - cycle_count=0
- Outputs are registered only; there is no combinational path from input to output.
- Latency:
  - halt, halt_cause and halt_pc assert on the rising edge that samples the triggering retire, i.e. 1 cycle after the strobe.
  - instr_count updates on that same edge.
  - The TIMEOUT halt asserts on the edge where the idle counter reaches TIMEOUT_CYCLES.
- After clear, halt deasserts on the next edge.

## Structure
- Package drisc_monitor_pkg holds:
  - the halt_cause_t enum (3 bits)
  - the monitor_state_t enum
  - the legal-opcode constants
  - the function is_legal_opcode(opcode)
- The counters use one sub-module, sat_counter, parametrised by WIDTH with inc/clr ports. It is instantiated for instr_count, cycle_count, the idle counter and the repeat counter.

## Test plan
- Straight-line program, MAX_INSTRUCTIONS=10: ten retires with pc_next = pc_current+4 → halt=1 and cause=3 one cycle after the tenth retire; instr_count=10.
- Self-loop with LOOP_REPEAT=3: after warmup, retires with pc_current = pc_next = 0x40 → halt on the third such retire; cause=1, halt_pc=0x40.
- Opcode 0x7F on the 2nd retire (inside warmup) → no halt. Opcode 0x7F on the 6th retire → cause=2, halt_pc equals that retire's PC.
- No retire for 64 cycles after the 5th retire → cause=4 on cycle 64, halt_pc=0, instr_count=5.
- Opcode 0x7F with pc_current = pc_next, LOOP_REPEAT=1, in RUN → cause=1 (priority). Then pulse clear → halt=0, counters=0, state WARMUP.
- Drop reset mid-run with instr_count=7 → all outputs read 0 before the next clock edge. The monitor resumes in WARMUP after reset is released.
